maze_player_ctrl: RTL and testbench
===================================

# maze_player_ctrl

Player-movement controller for the VGA maze game, sitting directly upstream of the `maze` renderer. It synchronizes and debounces the three active-low push buttons and tracks a player heading. It steps the player one grid cell per forward press after a wall lookup through a one-cycle-latency maze ROM port. It drives player cell, heading, move count and win status to the renderer, which draws from these registers.

## Interface
Parameters:
- `GRID_W`, 32: maze width in cells (640 px / 20 px).
- `GRID_H`, 24: maze height in cells.
- `START_X`, 1 / `START_Y`, 1: reset cell.
- `GOAL_X`, 30 / `GOAL_Y`, 22: winning cell.
- `DEBOUNCE_CYCLES`, 500000: stable cycles required to accept a key level (10 ms at 50 MHz).
- `REPEAT_CYCLES`, 12500000: forward auto-repeat period; used only with `MAZE_AUTOREPEAT_EN`.

Ports (XW = $clog2(GRID_W), YW = $clog2(GRID_H)):
- `iCLK` in 1: 50 MHz system clock (CLOCK_50). One clock domain; reset is synchronous and active-high.
- `iRST` in 1: synchronous reset, active-high.
- `iKEY_L_N` in 1: raw turn-left button, active-low, asynchronous (KEY[3]).
- `iKEY_R_N` in 1: raw turn-right button, active-low, asynchronous (KEY[2]).
- `iKEY_F_N` in 1: raw step-forward button, active-low, asynchronous (KEY[1]).
- `iRUN` in 1: game enable (SW[0]); when low, all presses are discarded.
- `oQ_X` out XW / `oQ_Y` out YW: wall-query cell address, registered.
- `iQ_WALL` in 1: wall flag for `oQ_X`/`oQ_Y`, valid one cycle after the address.
- `oPX` out XW / `oPY` out YW: player cell.
- `oDIR` out 2: heading, 0=N (y-1), 1=E (x+1), 2=S (y+1), 3=W (x-1).
- `oMOVES` out 10: successful step count, saturating.
- `oBUMP` out 1: one-cycle pulse on a blocked step.
- `oWIN` out 1: high once the goal is reached.

## Operation
- Each key passes through a 2-flop synchronizer and then a debouncer. The debounced level changes only after the synchronized input differs from it for `DEBOUNCE_CYCLES` consecutive cycles.
- A press is a one-cycle pulse on the debounced released→pressed transition.
- Same-cycle presses are prioritized F > L > R. Lower-priority presses are dropped.
- FSM states: IDLE, QUERY, CHECK, WON.
- IDLE, L press: oDIR ← oDIR−1 mod 4. R press: oDIR ← oDIR+1 mod 4. State remains IDLE.
- IDLE, F press: register the target cell (player + heading) into oQ_X/oQ_Y, latch an out-of-bounds flag, and move to QUERY.
  - Out-of-bounds means x<0, x≥GRID_W, y<0 or y≥GRID_H, computed at XW+1/YW+1 signed width.
  - For an out-of-bounds target, oQ holds the clamped current cell.
- QUERY: wait one cycle for ROM latency, then move to CHECK.
- CHECK:
  - If iQ_WALL or the out-of-bounds flag is set: oBUMP=1 for this cycle; position and count are unchanged.
  - Otherwise: oPX/oPY ← target, and oMOVES increments, saturating at 1023.
  - Next state is WON if the new cell equals GOAL, else IDLE.
- WON: oWIN=1. All presses are ignored until reset.
- Presses arriving in QUERY or CHECK are dropped.
- iRUN low: the press pulse is masked before the FSM, and debouncers keep running. A step already in QUERY/CHECK completes.

## Timing
- Reset values:
  - oPX=START_X, oPY=START_Y, oDIR=1, oMOVES=0, oBUMP=0, oWIN=0.
  - oQ_X=START_X, oQ_Y=START_Y, state IDLE.
  - Debounced levels = released, counters 0.
- A key held through reset yields one press DEBOUNCE_CYCLES+2 cycles after reset deasserts.
- Raw edge to press pulse: 2 + DEBOUNCE_CYCLES cycles.
- Turn: oDIR updates on the clock edge after the press pulse.
- Step: oPX/oPY/oMOVES/oBUMP update 3 edges after the press pulse (IDLE→QUERY→CHECK→register).
- iRST asserted in any state, including mid-step, restores all reset values on the next edge. Any pending ROM result is discarded.

## Configuration
- `MAZE_AUTOREPEAT_EN` defined:
  - While the forward key stays debounced-pressed in IDLE, an extra forward press is generated every REPEAT_CYCLES cycles after the initial press.
  - The repeat counter clears on release, on reset and while iRUN is low.
- Not defined: exactly one step per press; the repeat counter is not built.

## Structure
- Package `maze_pkg`:
  - `dir_t` heading encoding.
  - `state_t` FSM enum.
  - GRID_W/GRID_H defaults and the cell pixel size (20).
- Sub-module `key_debounce` (synchronizer + counter + press pulse), instantiated three times.

## Test plan
Bench uses DEBOUNCE_CYCLES=4 and REPEAT_CYCLES=16.
- Reset → oPX=1, oPY=1, oDIR=1, oMOVES=0, oWIN=0.
- F press, iQ_WALL=0 → oQ=(2,1); 3 cycles after the press pulse oPX=2, oMOVES=1, no oBUMP.
- Bounce: toggle iKEY_F_N every 2 cycles for 20 cycles, then hold low → exactly one step.
- Heading N from (1,0), F press → out-of-bounds; oBUMP one cycle; position (1,0); oMOVES unchanged. Repeat with iQ_WALL=1 on an in-grid target → same response.
- Same-cycle F+L press → step taken, oDIR unchanged. L press at oDIR=0 → oDIR=3.
- Step into (30,22) → oWIN=1; later presses change nothing. iRST mid-QUERY → state returns to reset values, no step. With MAZE_AUTOREPEAT_EN, holding F for 40 cycles after the press → 3 steps.

Source files
------------

// File: rtl/maze_pkg.sv
`default_nettype none
// ============================================================================
// Module      : maze_pkg
// Description : Shared types and constants for the maze player controller:
//               heading encoding, controller FSM states, default grid size
//               and the renderer's cell size in pixels.
// Revision    : 1.0 - initial release
// ============================================================================
package maze_pkg;

  localparam int C_GRID_W  = 32;   // 640 px / 20 px
  localparam int C_GRID_H  = 24;   // 480 px / 20 px
  localparam int C_CELL_PX = 20;

  // Heading: N moves y-1, E moves x+1, S moves y+1, W moves x-1
  typedef enum logic [1:0] {
    DIR_N = 2'd0,
    DIR_E = 2'd1,
    DIR_S = 2'd2,
    DIR_W = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_QUERY = 2'd1,
    ST_CHECK = 2'd2,
    ST_WON   = 2'd3
  } state_t;

endpackage : maze_pkg
`default_nettype wire

// File: rtl/maze_player_ctrl_key_debounce.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce
// Description : Two-flop synchronizer, stability counter and press pulse for
//               one active-low push button. The debounced level flips only
//               after the synchronized key has disagreed with it for
//               DEBOUNCE_CYCLES consecutive cycles; o_press pulses for one
//               cycle on the released->pressed flip.
// Revision    : 1.0 - initial release
// ============================================================================
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_key_n,
  output logic o_level,
  output logic o_press
);

  localparam int              c_cnt_w   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_CYCLES - 1);

  logic [1:0]         r_sync;
  logic               r_level;
  logic               r_press;
  logic [c_cnt_w-1:0] r_cnt;
  logic               w_pressed;

  assign w_pressed = ~r_sync[1];

  // Synchronize the raw key, count consecutive disagreeing cycles, flip level
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync  <= 2'b11;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync  <= {r_sync[0], i_key_n};
      r_press <= 1'b0;
      if (w_pressed == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == c_cnt_max) begin
        r_cnt   <= '0;
        r_level <= w_pressed;
        r_press <= w_pressed;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;
  assign o_press = r_press;

endmodule : key_debounce
`default_nettype wire

// File: rtl/maze_player_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : maze_player_ctrl
// Description : Player-movement controller for the VGA maze. Debounces the
//               turn-left / turn-right / forward keys, tracks heading, and
//               steps the player one cell per forward press after a wall
//               lookup through a one-cycle-latency maze ROM port.
//               Optional build macro: MAZE_AUTOREPEAT_EN (forward auto-repeat
//               every REPEAT_CYCLES while the forward key is held).
// Revision    : 1.0 - initial release
// ============================================================================
module maze_player_ctrl
  import maze_pkg::*;
#(
  parameter int GRID_W          = C_GRID_W,
  parameter int GRID_H          = C_GRID_H,
  parameter int START_X         = 1,
  parameter int START_Y         = 1,
  parameter int GOAL_X          = 30,
  parameter int GOAL_Y          = 22,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_CYCLES   = 12500000,
  localparam int XW = $clog2(GRID_W),
  localparam int YW = $clog2(GRID_H)
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iKEY_L_N,
  input  logic          iKEY_R_N,
  input  logic          iKEY_F_N,
  input  logic          iRUN,
  output logic [XW-1:0] oQ_X,
  output logic [YW-1:0] oQ_Y,
  input  logic          iQ_WALL,
  output logic [XW-1:0] oPX,
  output logic [YW-1:0] oPY,
  output logic [1:0]    oDIR,
  output logic [9:0]    oMOVES,
  output logic          oBUMP,
  output logic          oWIN
);

  localparam logic [XW-1:0] c_start_x = XW'(START_X);
  localparam logic [YW-1:0] c_start_y = YW'(START_Y);
  localparam logic [XW-1:0] c_goal_x  = XW'(GOAL_X);
  localparam logic [YW-1:0] c_goal_y  = YW'(GOAL_Y);

  logic w_lvl_l, w_lvl_r, w_lvl_f;
  logic w_prs_l, w_prs_r, w_prs_f;
  logic w_rep;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_l (
    .clk(iCLK), .rst(iRST), .i_key_n(iKEY_L_N), .o_level(w_lvl_l), .o_press(w_prs_l));
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_r (
    .clk(iCLK), .rst(iRST), .i_key_n(iKEY_R_N), .o_level(w_lvl_r), .o_press(w_prs_r));
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_f (
    .clk(iCLK), .rst(iRST), .i_key_n(iKEY_F_N), .o_level(w_lvl_f), .o_press(w_prs_f));

  state_t          r_state, w_state_nxt;
  logic [XW-1:0]   r_px, w_px_nxt, r_qx, w_qx_nxt, r_tx, w_tx_nxt;
  logic [YW-1:0]   r_py, w_py_nxt, r_qy, w_qy_nxt, r_ty, w_ty_nxt;
  logic [1:0]      r_dir, w_dir_nxt;
  logic [9:0]      r_moves, w_moves_nxt;
  logic            r_bump, w_bump_nxt;
  logic            r_win, w_win_nxt;
  logic            r_oob, w_oob_nxt;
  logic            w_go_f, w_go_l, w_go_r;
  logic signed [XW:0] w_dx, w_tgt_x;
  logic signed [YW:0] w_dy, w_tgt_y;
  logic            w_oob;
  logic            w_ok;
  logic [XW-1:0]   w_cell_x;
  logic [YW-1:0]   w_cell_y;

`ifdef MAZE_AUTOREPEAT_EN
  localparam int                  c_rep_w   = $clog2(REPEAT_CYCLES + 1);
  localparam logic [c_rep_w-1:0]  c_rep_max = c_rep_w'(REPEAT_CYCLES - 1);
  logic [c_rep_w-1:0] r_rep_cnt;

  // Count held-forward cycles since the last (real or repeated) press
  always_ff @(posedge iCLK) begin
    if (iRST || !w_lvl_f || !iRUN || w_prs_f || w_rep) begin
      r_rep_cnt <= '0;
    end else begin
      r_rep_cnt <= r_rep_cnt + 1'b1;
    end
  end

  assign w_rep = w_lvl_f && (r_rep_cnt == c_rep_max);
`else
  assign w_rep = 1'b0;
`endif

  // Press priority F > L > R, all masked by the game enable
  assign w_go_f = (w_prs_f | w_rep) & iRUN;
  assign w_go_l = w_prs_l & iRUN & ~w_go_f;
  assign w_go_r = w_prs_r & iRUN & ~w_go_f & ~w_prs_l;

  // Target cell one step along the heading, with signed bounds check
  always_comb begin
    w_dx = '0;
    w_dy = '0;
    case (r_dir)
      DIR_N:   w_dy = '1;
      DIR_E:   w_dx = (XW+1)'(1);
      DIR_S:   w_dy = (YW+1)'(1);
      default: w_dx = '1;
    endcase
    w_tgt_x = $signed({1'b0, r_px}) + w_dx;
    w_tgt_y = $signed({1'b0, r_py}) + w_dy;
    w_oob   = w_tgt_x[XW] || (int'(w_tgt_x) >= GRID_W) ||
              w_tgt_y[YW] || (int'(w_tgt_y) >= GRID_H);
  end

  // FSM state register
  always_ff @(posedge iCLK) begin
    if (iRST) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // FSM next state and datapath next values
  always_comb begin
    w_state_nxt = r_state;
    w_px_nxt    = r_px;
    w_py_nxt    = r_py;
    w_qx_nxt    = r_qx;
    w_qy_nxt    = r_qy;
    w_tx_nxt    = r_tx;
    w_ty_nxt    = r_ty;
    w_oob_nxt   = r_oob;
    w_dir_nxt   = r_dir;
    w_moves_nxt = r_moves;
    w_bump_nxt  = 1'b0;
    w_win_nxt   = r_win;
    w_ok        = ~(iQ_WALL | r_oob);
    w_cell_x    = w_ok ? r_tx : r_px;
    w_cell_y    = w_ok ? r_ty : r_py;
    case (r_state)
      ST_IDLE: begin
        if (w_go_f) begin
          w_tx_nxt    = w_tgt_x[XW-1:0];
          w_ty_nxt    = w_tgt_y[YW-1:0];
          w_oob_nxt   = w_oob;
          w_qx_nxt    = w_oob ? r_px : w_tgt_x[XW-1:0];
          w_qy_nxt    = w_oob ? r_py : w_tgt_y[YW-1:0];
          w_state_nxt = ST_QUERY;
        end else if (w_go_l) begin
          w_dir_nxt = r_dir - 2'd1;
        end else if (w_go_r) begin
          w_dir_nxt = r_dir + 2'd1;
        end
      end
      ST_QUERY: w_state_nxt = ST_CHECK;
      ST_CHECK: begin
        if (w_ok) begin
          w_px_nxt    = r_tx;
          w_py_nxt    = r_ty;
          w_moves_nxt = (r_moves == 10'h3FF) ? r_moves : r_moves + 10'd1;
        end else begin
          w_bump_nxt = 1'b1;
        end
        if (w_cell_x == c_goal_x && w_cell_y == c_goal_y) begin
          w_state_nxt = ST_WON;
          w_win_nxt   = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_win_nxt = 1'b1;
    endcase
  end

  // Datapath registers
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_px    <= c_start_x;
      r_py    <= c_start_y;
      r_qx    <= c_start_x;
      r_qy    <= c_start_y;
      r_tx    <= c_start_x;
      r_ty    <= c_start_y;
      r_oob   <= 1'b0;
      r_dir   <= DIR_E;
      r_moves <= '0;
      r_bump  <= 1'b0;
      r_win   <= 1'b0;
    end else begin
      r_px    <= w_px_nxt;
      r_py    <= w_py_nxt;
      r_qx    <= w_qx_nxt;
      r_qy    <= w_qy_nxt;
      r_tx    <= w_tx_nxt;
      r_ty    <= w_ty_nxt;
      r_oob   <= w_oob_nxt;
      r_dir   <= w_dir_nxt;
      r_moves <= w_moves_nxt;
      r_bump  <= w_bump_nxt;
      r_win   <= w_win_nxt;
    end
  end

  assign oQ_X   = r_qx;
  assign oQ_Y   = r_qy;
  assign oPX    = r_px;
  assign oPY    = r_py;
  assign oDIR   = r_dir;
  assign oMOVES = r_moves;
  assign oBUMP  = r_bump;
  assign oWIN   = r_win;

endmodule : maze_player_ctrl
`default_nettype wire

// File: tb/tb_maze_player_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_maze_player_ctrl
// Description : Directed self-checking bench for maze_player_ctrl with
//               DEBOUNCE_CYCLES=4 and REPEAT_CYCLES=16. A key driven low at a
//               negedge yields a press pulse after the 6th rising edge; turns
//               and oQ show at the 7th, steps and bumps at the 9th.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_maze_player_ctrl;

  localparam int XW = 5;
  localparam int YW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          key_l_n = 1'b1, key_r_n = 1'b1, key_f_n = 1'b1;
  logic          run = 1'b1;
  logic [XW-1:0] q_x, px;
  logic [YW-1:0] q_y, py;
  logic          q_wall = 1'b0;
  logic [1:0]    dir;
  logic [9:0]    moves;
  logic          bump, win;
  logic          wall_en = 1'b0;
  logic [XW-1:0] wall_x = '0;
  logic [YW-1:0] wall_y = '0;
  int            total = 0;
  int            bad = 0;

  maze_player_ctrl #(.DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(16)) dut (
    .iCLK(clk), .iRST(rst), .iKEY_L_N(key_l_n), .iKEY_R_N(key_r_n), .iKEY_F_N(key_f_n),
    .iRUN(run), .oQ_X(q_x), .oQ_Y(q_y), .iQ_WALL(q_wall), .oPX(px), .oPY(py),
    .oDIR(dir), .oMOVES(moves), .oBUMP(bump), .oWIN(win));

  always #5 clk = ~clk;

  // One-cycle-latency wall ROM holding at most one wall cell
  always @(posedge clk) q_wall <= wall_en && (q_x == wall_x) && (q_y == wall_y);

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; key_l_n = 1'b1; key_r_n = 1'b1; key_f_n = 1'b1;
    cyc(2);
    rst = 1'b0;
  endtask

  // Drive keys low; returns at the negedge after the FSM consumed the press
  task automatic press(input bit f, input bit l, input bit r);
    key_f_n = ~f; key_l_n = ~l; key_r_n = ~r;
    cyc(7);
  endtask

  task automatic release_all();
    key_f_n = 1'b1; key_l_n = 1'b1; key_r_n = 1'b1;
    cyc(8);
  endtask

  task automatic test_reset();
    cyc(3);
    rst = 1'b0;
    cyc(1);
    total++; if (px !== 5'd1) begin bad++; $display("FAIL reset_px got=%0d want=1", px); end
    total++; if (py !== 5'd1) begin bad++; $display("FAIL reset_py got=%0d want=1", py); end
    total++; if (dir !== 2'd1) begin bad++; $display("FAIL reset_dir got=%0d want=1", dir); end
    total++; if (moves !== 10'd0) begin bad++; $display("FAIL reset_moves got=%0d want=0", moves); end
    total++; if (bump !== 1'b0) begin bad++; $display("FAIL reset_bump got=%0b want=0", bump); end
    total++; if (win !== 1'b0) begin bad++; $display("FAIL reset_win got=%0b want=0", win); end
    total++; if (q_x !== 5'd1 || q_y !== 5'd1) begin bad++; $display("FAIL reset_q got=(%0d,%0d) want=(1,1)", q_x, q_y); end
  endtask

  task automatic test_step();
    press(1, 0, 0);
    total++; if (q_x !== 5'd2 || q_y !== 5'd1) begin bad++; $display("FAIL step_q got=(%0d,%0d) want=(2,1)", q_x, q_y); end
    cyc(1);
    total++; if (px !== 5'd1) begin bad++; $display("FAIL step_early_px got=%0d want=1", px); end
    cyc(1);
    total++; if (px !== 5'd2 || py !== 5'd1) begin bad++; $display("FAIL step_pos got=(%0d,%0d) want=(2,1)", px, py); end
    total++; if (moves !== 10'd1) begin bad++; $display("FAIL step_moves got=%0d want=1", moves); end
    total++; if (bump !== 1'b0) begin bad++; $display("FAIL step_bump got=%0b want=0", bump); end
    release_all();
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 10; i++) begin
      key_f_n = i[0];
      cyc(2);
    end
    total++; if (moves !== 10'd1) begin bad++; $display("FAIL bounce_none got=%0d want=1", moves); end
    key_f_n = 1'b0;
    cyc(12);
    release_all();
    total++; if (px !== 5'd3 || moves !== 10'd2) begin bad++; $display("FAIL bounce_one got=px%0d/m%0d want=px3/m2", px, moves); end
  endtask

  task automatic test_oob_wall();
    do_reset();
    press(0, 1, 0);
    total++; if (dir !== 2'd0) begin bad++; $display("FAIL turn_l got=%0d want=0", dir); end
    release_all();
    press(1, 0, 0); cyc(2);
    total++; if (px !== 5'd1 || py !== 5'd0) begin bad++; $display("FAIL north_step got=(%0d,%0d) want=(1,0)", px, py); end
    release_all();
    press(1, 0, 0);
    total++; if (q_x !== 5'd1 || q_y !== 5'd0) begin bad++; $display("FAIL oob_clamp got=(%0d,%0d) want=(1,0)", q_x, q_y); end
    cyc(2);
    total++; if (bump !== 1'b1) begin bad++; $display("FAIL oob_bump got=%0b want=1", bump); end
    total++; if (px !== 5'd1 || py !== 5'd0 || moves !== 10'd1) begin bad++; $display("FAIL oob_hold got=(%0d,%0d)m%0d want=(1,0)m1", px, py, moves); end
    cyc(1);
    total++; if (bump !== 1'b0) begin bad++; $display("FAIL oob_bump_pulse got=%0b want=0", bump); end
    release_all();
    wall_en = 1'b1; wall_x = 5'd2; wall_y = 5'd0;
    press(0, 0, 1);
    total++; if (dir !== 2'd1) begin bad++; $display("FAIL turn_r got=%0d want=1", dir); end
    release_all();
    press(1, 0, 0);
    total++; if (q_x !== 5'd2 || q_y !== 5'd0) begin bad++; $display("FAIL wall_q got=(%0d,%0d) want=(2,0)", q_x, q_y); end
    cyc(2);
    total++; if (bump !== 1'b1) begin bad++; $display("FAIL wall_bump got=%0b want=1", bump); end
    total++; if (px !== 5'd1 || moves !== 10'd1) begin bad++; $display("FAIL wall_hold got=px%0d/m%0d want=px1/m1", px, moves); end
    release_all();
    wall_en = 1'b0;
    press(0, 1, 0); release_all();
    press(0, 1, 0);
    total++; if (dir !== 2'd3) begin bad++; $display("FAIL wrap_l got=%0d want=3", dir); end
    release_all();
    press(0, 0, 1);
    total++; if (dir !== 2'd0) begin bad++; $display("FAIL wrap_r got=%0d want=0", dir); end
    release_all();
  endtask

  task automatic test_priority();
    do_reset();
    press(1, 1, 0);
    total++; if (dir !== 2'd1) begin bad++; $display("FAIL fl_dir got=%0d want=1", dir); end
    cyc(2);
    total++; if (px !== 5'd2 || moves !== 10'd1) begin bad++; $display("FAIL fl_step got=px%0d/m%0d want=px2/m1", px, moves); end
    release_all();
    press(0, 1, 1);
    total++; if (dir !== 2'd0) begin bad++; $display("FAIL lr_dir got=%0d want=0", dir); end
    release_all();
  endtask

  task automatic test_run_gate();
    run = 1'b0;
    press(1, 0, 0); cyc(2);
    total++; if (px !== 5'd2 || py !== 5'd1 || moves !== 10'd1) begin bad++; $display("FAIL run_f got=(%0d,%0d)m%0d want=(2,1)m1", px, py, moves); end
    release_all();
    press(0, 0, 1);
    total++; if (dir !== 2'd0) begin bad++; $display("FAIL run_r got=%0d want=0", dir); end
    release_all();
    run = 1'b1;
  endtask

  task automatic test_reset_mid();
    do_reset();
    press(1, 1, 0);
    rst = 1'b1; key_f_n = 1'b1; key_l_n = 1'b1;
    cyc(1);
    rst = 1'b0;
    total++; if (q_x !== 5'd1 || q_y !== 5'd1) begin bad++; $display("FAIL mid_q got=(%0d,%0d) want=(1,1)", q_x, q_y); end
    cyc(12);
    total++; if (px !== 5'd1 || py !== 5'd1 || moves !== 10'd0) begin bad++; $display("FAIL mid_nostep got=(%0d,%0d)m%0d want=(1,1)m0", px, py, moves); end
    total++; if (dir !== 2'd1 || bump !== 1'b0) begin bad++; $display("FAIL mid_dir got=%0d/b%0b want=1/b0", dir, bump); end
  endtask

  task automatic test_win();
    do_reset();
    for (int i = 0; i < 29; i++) begin press(1, 0, 0); cyc(2); release_all(); end
    total++; if (win !== 1'b0 || px !== 5'd30) begin bad++; $display("FAIL prewin got=w%0b/px%0d want=w0/px30", win, px); end
    press(0, 0, 1); release_all();
    for (int i = 0; i < 21; i++) begin press(1, 0, 0); cyc(2); release_all(); end
    total++; if (win !== 1'b1) begin bad++; $display("FAIL win got=%0b want=1", win); end
    total++; if (px !== 5'd30 || py !== 5'd22 || moves !== 10'd50) begin bad++; $display("FAIL win_pos got=(%0d,%0d)m%0d want=(30,22)m50", px, py, moves); end
    press(1, 1, 0); cyc(2); release_all();
    press(0, 0, 1); release_all();
    total++; if (dir !== 2'd2 || px !== 5'd30 || py !== 5'd22 || moves !== 10'd50 || win !== 1'b1) begin
      bad++; $display("FAIL win_frozen got=d%0d(%0d,%0d)m%0d w%0b want=d2(30,22)m50 w1", dir, px, py, moves, win);
    end
  endtask

  task automatic test_hold();
    do_reset();
    key_f_n = 1'b0;
    cyc(46);
    key_f_n = 1'b1;
    cyc(12);
`ifdef MAZE_AUTOREPEAT_EN
    total++; if (px !== 5'd4 || moves !== 10'd3) begin bad++; $display("FAIL hold_repeat got=px%0d/m%0d want=px4/m3", px, moves); end
`else
    total++; if (px !== 5'd2 || moves !== 10'd1) begin bad++; $display("FAIL hold_single got=px%0d/m%0d want=px2/m1", px, moves); end
`endif
  endtask

  initial begin
    test_reset();
    test_step();
    test_bounce();
    test_oob_wall();
    test_priority();
    test_run_gate();
    test_reset_mid();
    test_win();
    test_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_maze_player_ctrl
`default_nettype wire
